// File: rtl/req_encoder.sv
// Sequential priority encoder: latches pulsed request lines and presents the lowest pending index on valid/ready.
// Latency 2 cycles from idle; 1 index/cycle sustained; code holds while out_ready is low.
module req_encoder #(
   parameter int N = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [N-1:0]         req_in,
   input  logic                 out_ready,
   input  logic                 overrun_clr,
   output logic                 out_valid,
   output logic [$clog2(N)-1:0] code,
   output logic [N-1:0]         pending,
   output logic                 overrun
);

   localparam int W = $clog2(N);

   typedef enum logic {
      IDLE    = 1'b0,
      PRESENT = 1'b1
   } state_t;

   state_t         state_q, state_d;
   logic [W-1:0]   code_q, code_d;
   logic [N-1:0]   pending_q, pending_d;
   logic           overrun_q, overrun_d;

   logic           hs;
   logic [N-1:0]   served;
   logic [N-1:0]   rem;

   // Descending scan so the last assignment is the lowest set index.
   function automatic logic [W-1:0] lowest_idx(input logic [N-1:0] v);
      lowest_idx = '0;
      for (int i = N - 1; i >= 0; i--) begin
         if (v[i]) lowest_idx = W'(i);
      end
   endfunction

   always_comb begin
      hs        = (state_q == PRESENT) && out_ready;
      served    = '0;
      if (hs) served[code_q] = 1'b1;
      rem       = pending_q & ~served;
      pending_d = rem | req_in;
      // A request landing on a line still pending (and not just served) loses an event.
      overrun_d = (|(req_in & rem)) | (overrun_q & ~overrun_clr);
   end

   always_comb begin
      state_d = state_q;
      code_d  = code_q;
      unique case (state_q)
         IDLE: begin
            if (pending_q != '0) begin
               code_d  = lowest_idx(pending_q);
               state_d = PRESENT;
            end
         end
         PRESENT: begin
            if (hs) begin
               if (rem != '0) code_d  = lowest_idx(rem);
               else           state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         code_q    <= '0;
         pending_q <= '0;
         overrun_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         code_q    <= code_d;
         pending_q <= pending_d;
         overrun_q <= overrun_d;
      end
   end

   assign out_valid = (state_q == PRESENT);
   assign code      = code_q;
   assign pending   = pending_q;
   assign overrun   = overrun_q;

endmodule

// File: tb/tb_req_encoder.sv
// Bench for req_encoder: directed vectors, literal expectations, and a per-cycle reference model.
module tb_req_encoder;

   localparam int N = 4;

   logic         clk = 1'b0;
   logic         rst;
   logic [N-1:0] req_in;
   logic         out_ready;
   logic         overrun_clr;
   logic         out_valid;
   logic [1:0]   code;
   logic [N-1:0] pending;
   logic         overrun;

   always #5 clk = ~clk;

   req_encoder #(.N(N)) dut (
      .clk(clk), .rst(rst), .req_in(req_in), .out_ready(out_ready),
      .overrun_clr(overrun_clr), .out_valid(out_valid), .code(code),
      .pending(pending), .overrun(overrun)
   );

   int checks = 0;
   int failures = 0;

   function automatic void chk(string name, int act, int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
      end
   endfunction

   // Reference model: a set of pending line events plus "what is on the output".
   bit [N-1:0] m_pend  = '0;
   bit         m_valid = 1'b0;
   int         m_code  = 0;
   bit         m_ovr   = 1'b0;
   bit         chk_en  = 1'b0;

   function automatic int first_set(bit [N-1:0] v);
      for (int i = 0; i < N; i++) if (v[i]) return i;
      return 0;
   endfunction

   always @(posedge clk) begin : model
      bit [N-1:0] rem;
      bit         lost;
      if (rst) begin
         m_pend = '0; m_valid = 1'b0; m_code = 0; m_ovr = 1'b0;
      end else begin
         rem = m_pend;
         if (m_valid && out_ready) rem[m_code] = 1'b0;
         lost = 1'b0;
         for (int i = 0; i < N; i++) if (req_in[i] && rem[i]) lost = 1'b1;
         if (m_valid) begin
            if (out_ready) begin
               if (rem != 0) m_code = first_set(rem);
               else          m_valid = 1'b0;
            end
         end else if (m_pend != 0) begin
            m_valid = 1'b1;
            m_code  = first_set(m_pend);
         end
         m_pend = rem | bit'(0) | req_in;
         m_ovr  = lost || (m_ovr && !overrun_clr);
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         chk("model_out_valid", int'(out_valid), int'(m_valid));
         chk("model_pending", int'(pending), int'(m_pend));
         chk("model_overrun", int'(overrun), int'(m_ovr));
         if (m_valid) chk("model_code", int'(code), m_code);
      end
   end

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   logic [N-1:0] vreq [0:15] = '{4'b0110, 4'b0000, 4'b1001, 4'b0000, 4'b0001, 4'b0010,
                                 4'b0000, 4'b1111, 4'b0000, 4'b0100, 4'b0000, 4'b1000,
                                 4'b0011, 4'b0000, 4'b0101, 4'b0000};
   bit           vrdy [0:15] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1,
                                 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};

   initial begin
      rst = 1'b1; req_in = 4'b1111; out_ready = 1'b0; overrun_clr = 1'b0;
      step();
      chk_en = 1'b1;
      chk("reset_pending", int'(pending), 0);
      chk("reset_valid", int'(out_valid), 0);
      chk("reset_code", int'(code), 0);
      chk("reset_overrun", int'(overrun), 0);
      rst = 1'b0; req_in = '0;
      step();

      // Single request, 2-cycle latency
      req_in = 4'b0100; out_ready = 1'b1;
      step();
      chk("single_pending", int'(pending), 4'b0100);
      chk("single_valid_early", int'(out_valid), 0);
      req_in = '0;
      step();
      chk("single_valid", int'(out_valid), 1);
      chk("single_code", int'(code), 2);
      step();
      chk("single_drained", int'(pending), 0);
      chk("single_idle", int'(out_valid), 0);

      // Priority drain with stall; late higher-priority request does not pre-empt
      out_ready = 1'b0; req_in = 4'b1010;
      step();
      req_in = '0;
      step();
      chk("stall_code_a", int'(code), 1);
      step();
      step();
      chk("stall_code_b", int'(code), 1);
      req_in = 4'b0001;
      step();
      chk("stall_no_preempt", int'(code), 1);
      chk("stall_pending", int'(pending), 4'b1011);
      req_in = '0; out_ready = 1'b1;
      step();
      chk("drain_code0", int'(code), 0);
      step();
      chk("drain_code3", int'(code), 3);
      step();
      chk("drain_done", int'(out_valid), 0);
      chk("drain_overrun", int'(overrun), 0);

      // Overrun: set wins over clear, clear alone clears
      out_ready = 1'b0; req_in = 4'b1000;
      step();
      req_in = '0;
      step();
      req_in = 4'b1000;
      step();
      chk("ovr_set", int'(overrun), 1);
      chk("ovr_pending", int'(pending), 4'b1000);
      overrun_clr = 1'b1;
      step();
      chk("ovr_set_beats_clr", int'(overrun), 1);
      req_in = '0;
      step();
      chk("ovr_cleared", int'(overrun), 0);
      overrun_clr = 1'b0;

      // Serve-and-rerequest on the same line
      out_ready = 1'b1; req_in = 4'b1000;
      step();
      chk("rereq_no_ovr", int'(overrun), 0);
      chk("rereq_pending", int'(pending), 4'b1000);
      out_ready = 1'b0; req_in = '0;
      step();
      chk("rereq_valid", int'(out_valid), 1);
      chk("rereq_code", int'(code), 3);

      // Reset mid-stream
      req_in = 4'b1111;
      step();
      chk("full_pending", int'(pending), 4'b1111);
      req_in = '0; rst = 1'b1;
      step();
      rst = 1'b0;
      chk("mid_rst_pending", int'(pending), 0);
      chk("mid_rst_valid", int'(out_valid), 0);
      chk("mid_rst_overrun", int'(overrun), 0);
      chk("mid_rst_code", int'(code), 0);
      out_ready = 1'b1;
      step();
      step();
      chk("post_rst_quiet", int'(out_valid), 0);

      // Mixed vectors, model-checked every cycle
      for (int k = 0; k < 16; k++) begin
         req_in = vreq[k]; out_ready = vrdy[k]; overrun_clr = (k == 9);
         step();
      end
      req_in = '0; out_ready = 1'b1; overrun_clr = 1'b0;
      for (int k = 0; k < 8; k++) step();
      chk("final_empty", int'(pending), 0);
      chk("final_idle", int'(out_valid), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
